// File: rtl/cdc_handshake_tx_if.sv
// Bundle of the local send port and the req/ack crossing seen by the source-side transmitter.
// The transmitter takes the master view; local logic plus the destination take the slave view.
interface cdc_handshake_tx_if #(
  parameter int BUS_WIDTH = 8,
  parameter int CNT_WIDTH = 8
);
  logic                 tx_valid;
  logic [BUS_WIDTH-1:0] tx_data;
  logic                 tx_ready;
  logic                 ack_async;
  logic                 req_out;
  logic [BUS_WIDTH-1:0] data_out;
  logic                 done;
  logic                 busy;
  logic [CNT_WIDTH-1:0] xfer_cnt;

  modport master (
    input  tx_valid, tx_data, ack_async,
    output tx_ready, req_out, data_out, done, busy, xfer_cnt
  );

  modport slave (
    output tx_valid, tx_data, ack_async,
    input  tx_ready, req_out, data_out, done, busy, xfer_cnt
  );
endinterface

// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack clock-domain crossing: holds a word stable on data_out,
// raises req, and completes once the synchronized ack has risen and fallen again.
module cdc_handshake_tx #(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2,
  parameter int CNT_WIDTH  = 8
) (
  input logic                clk,
  input logic                rst_n,
  cdc_handshake_tx_if.master bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  state_t                state;
  logic [NUM_STAGES-1:0] ack_stages;
  logic                  ack_sync;
  logic                  ready;
  logic                  accept;
  logic                  req_q;
  logic                  done_q;
  logic [BUS_WIDTH-1:0]  data_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  // ack comes from a foreign clock domain; NUM_STAGES must be at least 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_stages <= '0;
    end else begin
      ack_stages <= {ack_stages[NUM_STAGES-2:0], bus.ack_async};
    end
  end

  assign ack_sync = ack_stages[NUM_STAGES-1];

  // A stale ack left high by the destination blocks new words until it has dropped
  assign ready  = (state == IDLE) && !ack_sync;
  assign accept = bus.tx_valid && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      req_q  <= 1'b0;
      data_q <= '0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            data_q <= bus.tx_data;
            req_q  <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (ack_sync) begin
            req_q <= 1'b0;
            state <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!ack_sync) begin
            done_q <= 1'b1;
            cnt_q  <= cnt_q + CNT_WIDTH'(1);
            state  <= IDLE;
          end
        end
        default: begin
          req_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx_ready = ready;
  assign bus.req_out  = req_q;
  assign bus.data_out = data_q;
  assign bus.done     = done_q;
  assign bus.busy     = (state != IDLE);
  assign bus.xfer_cnt = cnt_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx: exact-timing handshakes with a hand-driven ack,
// a destination-clock responder model, and a narrow-counter instance for wrap-around.
module tb_cdc_handshake_tx;

  logic clk = 1'b0;
  logic dclk = 1'b0;
  logic rst_n = 1'b0;
  int   dstHalf = 23;

  logic useResponder = 1'b1;
  logic manualAck = 1'b0;
  logic ack2 = 1'b0;
  logic respAck, reqMeta, reqSeen;
  int   respDelay;

  int checkCount = 0;
  int errorCount = 0;
  int doneCount = 0;
  int holdViolations = 0;
  logic monitorOn = 1'b0;
  logic [7:0] prevData = 8'h00;
  logic prevReady = 1'b0;
  logic prevReq = 1'b0;

  logic [7:0] recvQ[$];
  logic [7:0] sentQ[$];

  cdc_handshake_tx_if #(.BUS_WIDTH(8), .CNT_WIDTH(8)) bus ();
  cdc_handshake_tx_if #(.BUS_WIDTH(8), .CNT_WIDTH(2)) bus2 ();

  cdc_handshake_tx #(.BUS_WIDTH(8), .NUM_STAGES(2), .CNT_WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  cdc_handshake_tx #(.BUS_WIDTH(8), .NUM_STAGES(2), .CNT_WIDTH(2)) dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus2)
  );

  always #31 clk = ~clk;
  always #(dstHalf) dclk = ~dclk;

  assign bus.ack_async  = useResponder ? respAck : manualAck;
  assign bus2.ack_async = ack2;

  // Destination model: syncs req, acks 2 dst cycles later, captures the word, and
  // drops ack 2 dst cycles after it sees req low
  always @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      reqMeta   <= 1'b0;
      reqSeen   <= 1'b0;
      respAck   <= 1'b0;
      respDelay <= 0;
    end else begin
      reqMeta <= bus.req_out;
      reqSeen <= reqMeta;
      if (reqSeen != respAck) begin
        if (respDelay == 1) begin
          respAck   <= reqSeen;
          respDelay <= 0;
          if (reqSeen) recvQ.push_back(bus.data_out);
        end else begin
          respDelay <= respDelay + 1;
        end
      end else begin
        respDelay <= 0;
      end
    end
  end

  // A legal data_out change needs tx_ready=1 (IDLE, ack_sync=0) and req_out=0 just before it
  always @(negedge clk) begin
    if (bus.done) doneCount++;
    if (monitorOn && (bus.data_out != prevData) && !(prevReady && !prevReq)) holdViolations++;
    prevData  = bus.data_out;
    prevReady = bus.tx_ready;
    prevReq   = bus.req_out;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data);
    bus.tx_valid = valid;
    bus.tx_data  = data;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic resetDut();
    monitorOn = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic sendWord(input logic [7:0] data);
    bit accepted = 1'b0;
    applyStimulus(1'b1, data);
    for (int i = 0; i < 400 && !accepted; i++) begin
      if (bus.tx_ready) accepted = 1'b1;
      @(negedge clk);
    end
    if (!accepted) checkOutput("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wrapTransfer(input logic [7:0] data, input logic [1:0] expCnt);
    bus2.tx_valid = 1'b1;
    bus2.tx_data  = data;
    @(negedge clk);
    bus2.tx_valid = 1'b0;
    ack2 = 1'b1;
    waitCycles(3);
    ack2 = 1'b0;
    waitCycles(3);
    checkOutput("wrap_done", {31'd0, bus2.done}, 32'd1);
    checkOutput("wrap_cnt", {30'd0, bus2.xfer_cnt}, {30'd0, expCnt});
  endtask

  initial begin
    int startDone;
    int guard;
    int target;
    logic [7:0] nextWord;
    int halves[5] = '{84, 41, 23, 15, 10};
    logic [1:0] wrapSeq[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    applyStimulus(1'b0, 8'h00);
    bus2.tx_valid = 1'b0;
    bus2.tx_data  = 8'h00;
    waitCycles(3);

    checkOutput("rst_req", {31'd0, bus.req_out}, 32'd0);
    checkOutput("rst_data", {24'd0, bus.data_out}, 32'd0);
    checkOutput("rst_done", {31'd0, bus.done}, 32'd0);
    checkOutput("rst_cnt", {24'd0, bus.xfer_cnt}, 32'd0);
    checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rel_ready", {31'd0, bus.tx_ready}, 32'd1);

    // Single transfer through the responder
    startDone = doneCount;
    applyStimulus(1'b1, 8'hA5);
    @(negedge clk);
    applyStimulus(1'b0, 8'h5A);
    checkOutput("t2_req", {31'd0, bus.req_out}, 32'd1);
    checkOutput("t2_data", {24'd0, bus.data_out}, 32'hA5);
    checkOutput("t2_busy", {31'd0, bus.busy}, 32'd1);
    checkOutput("t2_ready", {31'd0, bus.tx_ready}, 32'd0);
    waitCycles(150);
    checkOutput("t2_dones", doneCount - startDone, 32'd1);
    checkOutput("t2_cnt", {24'd0, bus.xfer_cnt}, 32'd1);
    checkOutput("t2_hold", {24'd0, bus.data_out}, 32'hA5);
    checkOutput("t2_req_low", {31'd0, bus.req_out}, 32'd0);
    checkOutput("t2_idle", {31'd0, bus.busy}, 32'd0);

    // Back-to-back with tx_valid held high
    resetDut();
    recvQ.delete();
    holdViolations = 0;
    monitorOn = 1'b1;
    startDone = doneCount;
    sendWord(8'h01);
    sendWord(8'h02);
    sendWord(8'h03);
    applyStimulus(1'b0, 8'h00);
    waitCycles(300);
    monitorOn = 1'b0;
    checkOutput("t3_dones", doneCount - startDone, 32'd3);
    checkOutput("t3_cnt", {24'd0, bus.xfer_cnt}, 32'd3);
    checkOutput("t3_hold", holdViolations, 32'd0);
    checkOutput("t3_nrecv", recvQ.size(), 32'd3);
    if (recvQ.size() == 3) begin
      checkOutput("t3_w0", {24'd0, recvQ[0]}, 32'h01);
      checkOutput("t3_w1", {24'd0, recvQ[1]}, 32'h02);
      checkOutput("t3_w2", {24'd0, recvQ[2]}, 32'h03);
    end

    // Exact-timing handshake with hand-driven ack, then async reset mid-transfer
    useResponder = 1'b0;
    manualAck = 1'b0;
    resetDut();
    applyStimulus(1'b1, 8'h96);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00);
    manualAck = 1'b1;
    checkOutput("m_req0", {31'd0, bus.req_out}, 32'd1);
    @(negedge clk);
    checkOutput("m_req1", {31'd0, bus.req_out}, 32'd1);
    @(negedge clk);
    checkOutput("m_req2", {31'd0, bus.req_out}, 32'd1);
    @(negedge clk);
    checkOutput("m_req3", {31'd0, bus.req_out}, 32'd0);
    checkOutput("m_busy3", {31'd0, bus.busy}, 32'd1);
    manualAck = 1'b0;
    @(negedge clk);
    checkOutput("m_done4", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    checkOutput("m_done5", {31'd0, bus.done}, 32'd0);
    checkOutput("m_ready5", {31'd0, bus.tx_ready}, 32'd0);
    @(negedge clk);
    checkOutput("m_done6", {31'd0, bus.done}, 32'd1);
    checkOutput("m_cnt6", {24'd0, bus.xfer_cnt}, 32'd1);
    checkOutput("m_ready6", {31'd0, bus.tx_ready}, 32'd1);
    @(negedge clk);
    checkOutput("m_done7", {31'd0, bus.done}, 32'd0);

    applyStimulus(1'b1, 8'h3C);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00);
    checkOutput("t1_req", {31'd0, bus.req_out}, 32'd1);
    checkOutput("t1_data", {24'd0, bus.data_out}, 32'h3C);
    #10;
    rst_n = 1'b0;
    #1;
    checkOutput("t1_async_req", {31'd0, bus.req_out}, 32'd0);
    checkOutput("t1_async_data", {24'd0, bus.data_out}, 32'd0);
    checkOutput("t1_async_done", {31'd0, bus.done}, 32'd0);
    checkOutput("t1_async_cnt", {24'd0, bus.xfer_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t1_ready", {31'd0, bus.tx_ready}, 32'd1);

    // Stale ack held across reset release
    rst_n = 1'b0;
    manualAck = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    waitCycles(3);
    applyStimulus(1'b1, 8'hC3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("t4_ready_blk", {31'd0, bus.tx_ready}, 32'd0);
      checkOutput("t4_req_blk", {31'd0, bus.req_out}, 32'd0);
    end
    manualAck = 1'b0;
    @(negedge clk);
    checkOutput("t4_ready_s1", {31'd0, bus.tx_ready}, 32'd0);
    @(negedge clk);
    checkOutput("t4_ready_s2", {31'd0, bus.tx_ready}, 32'd1);
    checkOutput("t4_req_s2", {31'd0, bus.req_out}, 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00);
    checkOutput("t4_req_acc", {31'd0, bus.req_out}, 32'd1);
    checkOutput("t4_data_acc", {24'd0, bus.data_out}, 32'hC3);
    manualAck = 1'b1;
    waitCycles(3);
    manualAck = 1'b0;
    waitCycles(4);
    checkOutput("t4_cnt", {24'd0, bus.xfer_cnt}, 32'd1);

    // 2-bit counter wraps 3 -> 0
    resetDut();
    for (int i = 0; i < 5; i++) begin
      wrapTransfer(8'(i + 16), wrapSeq[i]);
    end

    // Randomised traffic across a sweep of destination clock rates
    useResponder = 1'b1;
    resetDut();
    recvQ.delete();
    sentQ.delete();
    holdViolations = 0;
    monitorOn = 1'b1;
    nextWord = 8'($urandom_range(0, 255));
    for (int p = 0; p < 5; p++) begin
      dstHalf = halves[p];
      target = (p + 1) * 40;
      guard = 0;
      while (sentQ.size() < target && guard < 6000) begin
        bus.tx_valid = 1'($urandom_range(0, 1));
        bus.tx_data  = nextWord;
        if (bus.tx_valid && bus.tx_ready) begin
          sentQ.push_back(nextWord);
          nextWord = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        guard++;
      end
    end
    applyStimulus(1'b0, 8'h00);
    guard = 0;
    while ((recvQ.size() < sentQ.size() || bus.busy) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    waitCycles(5);
    monitorOn = 1'b0;
    checkOutput("t6_sent", sentQ.size(), 32'd200);
    checkOutput("t6_recv", recvQ.size(), 32'd200);
    for (int i = 0; i < sentQ.size() && i < recvQ.size(); i++) begin
      checkOutput($sformatf("t6_word%0d", i), {24'd0, recvQ[i]}, {24'd0, sentQ[i]});
    end
    checkOutput("t6_cnt", {24'd0, bus.xfer_cnt}, 32'd200);
    checkOutput("t6_hold", holdViolations, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
